// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch: FSM encoding and BCD digit limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    // Run/pause state; the encoding is fixed so running can be read straight off the state bit.
    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } sw_state_e;

    // Largest legal value of the ones digit and of the tens digit in a 00..59 field.
    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    // True when a two-digit field sits at 59, the point where the next increment wraps.
    function automatic logic bcd_is_59(input logic [3:0] tens, input logic [3:0] ones);
        return (tens == BCD_TENS_MAX) && (ones == BCD_ONES_MAX);
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear and single-step increment.
// Latency: digits update on the clock edge after inc_i/clr_i; carry_o is combinational.
// Backpressure: none; every inc_i is consumed in the cycle it is presented.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       carry_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    // Next digit values: clear wins, otherwise step ones and ripple into tens.
    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        carry_o = 1'b0;
        if (clr_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc_i) begin
            carry_o = bcd_is_59(tens_q, ones_q);
            if (ones_q == BCD_ONES_MAX) begin
                ones_d = 4'd0;
                if (tens_q == BCD_TENS_MAX) begin
                    tens_d = 4'd0;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch: 1 Hz counting with run/pause toggle, synchronous clear and per-field manual adjust.
// Latency: digits, running and blink change one clock after the tick or pause edge that causes them.
// Backpressure: none; inputs are sampled levels and every tick is acted on in its own cycle.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       clr,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink
);

    // The prescaler spans half a second, so its wrap is the 2 Hz tick.
    localparam int unsigned HALF_SEC = CLK_HZ / 2;
    localparam int unsigned PW       = $clog2(HALF_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(HALF_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;
    logic          blink_q, blink_d;
    logic          pause_q;
    sw_state_e     state_q, state_d;

    logic tick_2hz;
    logic tick_1hz;
    logic pause_edge;
    logic count_en;
    logic sec_inc, min_inc;
    logic sec_carry, min_carry;
    logic unused_min_carry;

    // clr holds the prescaler at 0, which also masks any tick landing in a clr cycle.
    assign tick_2hz   = !clr && (presc_q == PRESC_MAX);
    // phase_q is 1 after an odd number of half-second ticks, so every second tick is a full second.
    assign tick_1hz   = tick_2hz && phase_q;
    assign pause_edge = pause && !pause_q;

    // Normal counting uses the current state, so a pause edge in the same cycle does not affect this tick.
    assign count_en = !adj && (state_q == ST_RUN) && tick_1hz;
    // In adjust mode only the selected field steps, and the seconds wrap never carries into minutes.
    assign sec_inc  = (adj && sel && tick_2hz) || count_en;
    assign min_inc  = (adj && !sel && tick_2hz) || (count_en && sec_carry);

    // Prescaler, 1 Hz phase and blink next-state.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        blink_d = blink_q;
        if (clr) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (tick_2hz) begin
            presc_d = '0;
            phase_d = !phase_q;
            blink_d = !blink_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    // Previous pause level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    // Run/pause next state: each pause rising edge flips it; clr leaves it alone.
    always_comb begin
        state_d = state_q;
        if (pause_edge) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // Run/pause state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    bcd_mod60 u_sec (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (sec_inc),
        .tens_o  (sec_tens),
        .ones_o  (sec_ones),
        .carry_o (sec_carry)
    );

    bcd_mod60 u_min (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (min_inc),
        .tens_o  (min_tens),
        .ones_o  (min_ones),
        .carry_o (min_carry)
    );

    // 59:59 simply wraps to 00:00; the minute carry has no further consumer.
    assign unused_min_carry = min_carry;

    assign running = (state_q == ST_RUN);
    assign blink   = blink_q;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pause  input  1  debounced, synchronous level; each rising edge toggles run/pause.
REQ-005 SHALL have port clr  input  1  synchronous level; while high, all digits are held at 00:00.
REQ-006 SHALL have port adj  input  1  adjust mode, 1 = manual set of one field.
REQ-007 SHALL have port sel  input  1  adjust field select, 0 = minutes, 1 = seconds.
REQ-008 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits, registered, feeding the per-digit seven-segment decoder.
REQ-009 SHALL have port running  output  1  1 when in RUN state.
REQ-010 SHALL have port blink  output  1  2 Hz square wave used to flash the adjusted field.

Function
REQ-011 SHALL contain a free-running prescaler counting 0..CLK_HZ/2-1, wrapping to 0, with width $clog2(CLK_HZ/2).
REQ-012 SHALL assert internal tick_2hz for one cycle when the prescaler equals CLK_HZ/2-1.
REQ-013 SHALL assert internal tick_1hz on every second tick_2hz, starting with the second one after reset or clr.
REQ-014 SHALL toggle blink on every tick_2hz.
REQ-015 SHALL implement a two-state FSM: PAUSE -> RUN and RUN -> PAUSE, each on a pause rising edge (registered pause compared with current pause).
REQ-016 SHALL apply an FSM transition in the cycle after the edge is seen; running reflects the state directly.
REQ-017 SHALL, in RUN with adj=0 and tick_1hz, increment mm:ss by one second, with the update visible on the outputs one cycle after the tick.
REQ-018 SHALL perform BCD carries as follows: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0.
REQ-019 SHALL wrap 59:59 to 00:00 on the next tick_1hz.
REQ-020 SHALL, with adj=1 and tick_2hz, increment the selected field by one modulo 60 with no carry into the other field, regardless of FSM state.
REQ-021 SHALL freeze the non-selected field and suppress normal counting while adj=1.
REQ-022 SHALL, while clr=1, force digits to 00:00 and the prescaler to 0, and clear the 1 Hz phase; clr SHALL NOT change FSM state or blink.
REQ-023 SHALL give clr priority over counting, adjust and any tick in the same cycle.
REQ-024 SHALL process a pause edge coinciding with a tick as follows: the tick uses the pre-edge state.
REQ-025 SHALL let a toggle of adj or sel take effect on the next tick_2hz, without resetting the prescaler.
REQ-026 SHALL treat non-BCD digit values as unreachable; no recovery logic is required.

Reset
REQ-027 SHALL, on rst high (asynchronous), set all digits to 0, prescaler to 0, 1 Hz phase to 0, blink to 0, FSM to PAUSE, running to 0, and the pause edge register to 0.
REQ-028 SHALL begin counting from prescaler 0 on the first clk edge after rst deasserts; rst mid-count discards the partial interval.

Structure
REQ-029 SHALL place the FSM state encodings (PAUSE=0, RUN=1) and BCD limit constants (9, 5) in the shared package stopwatch_pkg.
REQ-030 SHALL instantiate sub-module bcd_mod60 twice (minutes, seconds); each instance is a two-digit BCD 00..59 counter with inc, clr, carry-out (asserted on inc at 59).
REQ-031 SHALL be 120-400 lines of RTL in total, with no latches and all outputs driven from flops.

Verification (CLK_HZ=8: tick_2hz every 4 cycles, tick_1hz every 8)
REQ-032 SHALL cover reset then one pause pulse, run 80 cycles -> digits 00:10, running=1, blink toggles every 4 cycles.
REQ-033 SHALL cover preload by adj to 00:59, then run one second -> 01:00; preload 59:59, run one second -> 00:00.
REQ-034 SHALL cover adj=1, sel=1 from 00:58 for 3 tick_2hz -> 00:01 with minutes unchanged; sel=0 from 59:xx for 1 tick -> 00:xx.
REQ-035 SHALL cover clr asserted in the same cycle as tick_1hz at 00:09 -> 00:00, running unchanged, next increment 8 cycles after clr drops.
REQ-036 SHALL cover a pause edge coinciding with tick_1hz while in RUN at 00:03 -> 00:04 then PAUSE, with no further change over 40 cycles.
REQ-037 SHALL cover async rst asserted mid-interval at 12:34 between clk edges -> immediate 00:00, running=0, blink=0.
